// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit:
// state encoding, opcodes, ALU classes, mux selects, control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADDI  = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SW    = 3'b011;
    localparam logic [2:0] ALU_SLTI  = 3'b100;
    localparam logic [2:0] ALU_BEQ   = 3'b101;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Opcode/memory-handshake inputs and control-word outputs of the
// multicycle controller. master = controller, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] instr_op_i;
    logic                mem_ready_i;
    logic                PCWrite_o;
    logic                PCWriteCond_o;
    logic                IorD_o;
    logic                MemRead_o;
    logic                MemWrite_o;
    logic                IRWrite_o;
    logic                MemtoReg_o;
    logic                RegDst_o;
    logic                RegWrite_o;
    logic                ALUSrcA_o;
    logic [1:0]          ALUSrcB_o;
    logic [ALU_OP_W-1:0] ALU_op_o;
    logic [1:0]          PCSource_o;
    logic                illegal_o;
    logic [3:0]          state_o;
    logic [CNT_W-1:0]    retired_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output PCWrite_o, PCWriteCond_o, IorD_o,
        output MemRead_o, MemWrite_o, IRWrite_o,
        output MemtoReg_o, RegDst_o, RegWrite_o,
        output ALUSrcA_o, ALUSrcB_o, ALU_op_o,
        output PCSource_o, illegal_o, state_o,
        output retired_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o,
        input  MemRead_o, MemWrite_o, IRWrite_o,
        input  MemtoReg_o, RegDst_o, RegWrite_o,
        input  ALUSrcA_o, ALUSrcB_o, ALU_op_o,
        input  PCSource_o, illegal_o, state_o,
        input  retired_o
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Moore output map: state -> raw control word (no ready/reset gating).
// Ports: state_i current state, slti_i IR holds slti, ctrl_o word.
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   slti_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_RTYPE;
            end
            S_WB_R: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = slti_i ? ALU_SLTI : ALU_ADDI;
            end
            S_WB_I: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALU_BEQ;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_TRAP:  ctrl_o = '0;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: next-state FSM, memory-ready gating,
// retired counter, sticky trap. Ports: clk_i, rst_i, bus (master).
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 3,
    parameter int CNT_W       = 32,
    parameter int ENABLE_JUMP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic [OPCODE_W-1:0] op;
    logic op_r, op_imm, op_mem, op_beq;
    logic op_j, op_lw, op_slti, jump_ok;
    logic ready;
    logic retire;
    ctrl_t ctrl;

    assign op      = bus.instr_op_i;
    assign ready   = bus.mem_ready_i;
    assign op_slti = op == OPCODE_W'(OP_SLTI);
    assign op_lw   = op == OPCODE_W'(OP_LW);
    assign op_r    = op == OPCODE_W'(OP_RTYPE);
    assign op_imm  = op_slti || op == OPCODE_W'(OP_ADDI);
    assign op_mem  = op_lw || op == OPCODE_W'(OP_SW);
    assign op_beq  = op == OPCODE_W'(OP_BEQ);
    assign op_j    = op == OPCODE_W'(OP_J);
    assign jump_ok = op_j && (ENABLE_JUMP != 0);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    op_r:    state_d = S_EXEC_R;
                    op_imm:  state_d = S_EXEC_I;
                    op_mem:  state_d = S_MEM_ADDR;
                    op_beq:  state_d = S_BRANCH;
                    jump_ok: state_d = S_JUMP;
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_MEM_ADDR: begin
                state_d = op_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM,
            S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    ctrl_out_decode u_dec (
        .state_i (state_q),
        .slti_i  (op_slti),
        .ctrl_o  (ctrl)
    );

    // IR/PC load in FETCH only once the fetch completes;
    // reset suppresses every write and request.
    logic run, fetch_ok;
    assign run      = !rst_i;
    assign fetch_ok = (state_q != S_FETCH) || ready;

    assign bus.PCWrite_o     = run && ctrl.pc_write && fetch_ok;
    assign bus.IRWrite_o     = run && ctrl.ir_write && fetch_ok;
    assign bus.PCWriteCond_o = run && ctrl.pc_write_cond;
    assign bus.MemRead_o     = run && ctrl.mem_read;
    assign bus.MemWrite_o    = run && ctrl.mem_write;
    assign bus.RegWrite_o    = run && ctrl.reg_write;
    assign bus.IorD_o        = ctrl.iord;
    assign bus.MemtoReg_o    = ctrl.mem_to_reg;
    assign bus.RegDst_o      = ctrl.reg_dst;
    assign bus.ALUSrcA_o     = ctrl.alu_src_a;
    assign bus.ALUSrcB_o     = ctrl.alu_src_b;
    assign bus.ALU_op_o      = ALU_OP_W'(ctrl.alu_op);
    assign bus.PCSource_o    = ctrl.pc_source;
    assign bus.illegal_o     = illegal_q;
    assign bus.state_o       = state_q;
    assign bus.retired_o     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench: two controllers (jump on / 32-bit count, jump off / 4-bit
// count) driven alike and checked against a per-instruction path model.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] op_in = '0;
    logic rdy_in = 1'b1;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus_a ();
    multicycle_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.instr_op_i  = op_in;
    assign bus_a.mem_ready_i = rdy_in;
    assign bus_b.instr_op_i  = op_in;
    assign bus_b.mem_ready_i = rdy_in;

    multicycle_ctrl #(.ENABLE_JUMP(1), .CNT_W(32)) u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    multicycle_ctrl #(.ENABLE_JUMP(0), .CNT_W(4)) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    wire [16:0] act_a = {bus_a.PCWrite_o, bus_a.PCWriteCond_o,
        bus_a.IorD_o, bus_a.MemRead_o, bus_a.MemWrite_o,
        bus_a.IRWrite_o, bus_a.MemtoReg_o, bus_a.RegDst_o,
        bus_a.RegWrite_o, bus_a.ALUSrcA_o, bus_a.ALUSrcB_o,
        bus_a.ALU_op_o, bus_a.PCSource_o};
    wire [16:0] act_b = {bus_b.PCWrite_o, bus_b.PCWriteCond_o,
        bus_b.IorD_o, bus_b.MemRead_o, bus_b.MemWrite_o,
        bus_b.IRWrite_o, bus_b.MemtoReg_o, bus_b.RegDst_o,
        bus_b.RegWrite_o, bus_b.ALUSrcA_o, bus_b.ALUSrcB_o,
        bus_b.ALU_op_o, bus_b.PCSource_o};

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: each instruction is a list of states it must visit;
    // memory states repeat while ready is low; TRAP never ends.
    state_e path [2][6];
    int plen [2];
    int ppos [2];
    int unsigned ret [2];
    logic [5:0] cur_op;
    logic [5:0] op_q [$];
    bit rdy_q [$];
    bit rdy_rand = 1'b0;
    int n_done = 0;
    int icyc = 0;
    int istall = 0;
    logic [5:0] legal [6] = '{6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04};

    function automatic state_e cur(int k);
        if (ppos[k] < plen[k]) return path[k][ppos[k]];
        return S_FETCH;
    endfunction

    function automatic int base_cpi(logic [5:0] op);
        if (op == 6'h23) return 5;
        if (op == 6'h04 || op == 6'h02) return 3;
        return 4;
    endfunction

    task automatic load_path(int k, logic [5:0] op);
        ppos[k] = 0;
        path[k][0] = S_FETCH;
        path[k][1] = S_DECODE;
        plen[k] = 3;
        case (op)
            6'h00: begin
                path[k][2] = S_EXEC_R; path[k][3] = S_WB_R;
                plen[k] = 4;
            end
            6'h08, 6'h0a: begin
                path[k][2] = S_EXEC_I; path[k][3] = S_WB_I;
                plen[k] = 4;
            end
            6'h23: begin
                path[k][2] = S_MEM_ADDR; path[k][3] = S_MEM_RD;
                path[k][4] = S_WB_MEM; plen[k] = 5;
            end
            6'h2b: begin
                path[k][2] = S_MEM_ADDR; path[k][3] = S_MEM_WR;
                plen[k] = 4;
            end
            6'h04: path[k][2] = S_BRANCH;
            6'h02: path[k][2] = (k == 0) ? S_JUMP : S_TRAP;
            default: path[k][2] = S_TRAP;
        endcase
    endtask

    task automatic start_instr(bit all);
        if (op_q.size() > 0) cur_op = op_q.pop_front();
        else cur_op = legal[$urandom_range(5)];
        load_path(0, cur_op);
        if (all || cur(1) != S_TRAP) load_path(1, cur_op);
        icyc = 0;
        istall = 0;
    endtask

    task automatic step(int k);
        state_e s = cur(k);
        bit wt;
        if (s == S_TRAP) return;
        wt = (s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR)
             && !rdy_in;
        if (k == 0) begin
            icyc++;
            if (wt) istall++;
        end
        if (!wt) begin
            ppos[k]++;
            if (ppos[k] == plen[k]) begin
                ret[k]++;
                if (k == 0) begin
                    n_done++;
                    chk("cpi", icyc, base_cpi(cur_op) + istall);
                end
            end
        end
    endtask

    function automatic logic [16:0] exp_ctl(state_e s, bit rdy,
                                            bit r, logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'd0; ps = 2'd0; alu = 3'd0;
        case (s)
            S_FETCH: begin
                mr = 1; irw = rdy; pcw = rdy; sb = 1; alu = 3'b010;
            end
            S_DECODE: begin sb = 3; alu = 3'b010; end
            S_EXEC_R: begin sa = 1; sb = 0; alu = 3'b000; end
            S_WB_R: begin rd = 1; rw = 1; end
            S_EXEC_I: begin
                sa = 1; sb = 2;
                alu = (op == 6'h0a) ? 3'b100 : 3'b001;
            end
            S_WB_I: rw = 1;
            S_MEM_ADDR: begin sa = 1; sb = 2; alu = 3'b010; end
            S_MEM_RD: begin mr = 1; iord = 1; end
            S_WB_MEM: begin rw = 1; m2r = 1; end
            S_MEM_WR: begin mw = 1; iord = 1; end
            S_BRANCH: begin
                sa = 1; sb = 0; alu = 3'b101; pcwc = 1; ps = 1;
            end
            S_JUMP: begin pcw = 1; ps = 2; end
            default: ;
        endcase
        if (r) {pcw, pcwc, mr, mw, irw, rw} = '0;
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
                sb, alu, ps};
    endfunction

    task automatic cycle(bit do_rst);
        state_e sa = cur(0);
        state_e sb = cur(1);
        rst = do_rst;
        if (rdy_q.size() > 0) rdy_in = rdy_q.pop_front();
        else if (rdy_rand) rdy_in = ($urandom_range(3) != 0);
        else rdy_in = 1'b1;
        if (sa == S_DECODE || sa == S_MEM_ADDR || sa == S_EXEC_I)
            op_in = cur_op;
        else
            op_in = 6'($urandom);
        @(negedge clk);
        chk("ctl_a", act_a, exp_ctl(sa, rdy_in, do_rst, op_in));
        chk("ctl_b", act_b, exp_ctl(sb, rdy_in, do_rst, op_in));
        chk("st_a", bus_a.state_o, sa);
        chk("st_b", bus_b.state_o, sb);
        chk("ill_a", bus_a.illegal_o, sa == S_TRAP);
        chk("ill_b", bus_b.illegal_o, sb == S_TRAP);
        chk("ret_a", bus_a.retired_o, ret[0]);
        chk("ret_b", bus_b.retired_o, ret[1] & 32'd15);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (do_rst) begin
            ret[0] = 0;
            ret[1] = 0;
            start_instr(1'b1);
        end else begin
            step(0);
            step(1);
            if (ppos[0] == plen[0]) start_instr(1'b0);
        end
    endtask

    task automatic run_instrs(int n);
        int target = n_done + n;
        int budget = 100 * n;
        while (n_done < target && budget > 0) begin
            cycle(1'b0);
            budget--;
        end
        if (n_done < target) chk("timeout", n_done, target);
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_instr(1'b1);
        ret[0] = 0;
        ret[1] = 0;

        // lw zero-wait, then R-type with three fetch stalls
        op_q.push_back(6'h23);
        cycle(1'b1);
        run_instrs(1);
        op_q.push_back(6'h00);
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b0);
        run_instrs(1);

        // beq then sw back to back, then slti/addi
        op_q.push_back(6'h04);
        op_q.push_back(6'h2b);
        op_q.push_back(6'h0a);
        op_q.push_back(6'h08);
        run_instrs(4);

        // 16 addi wrap the 4-bit counter
        for (int i = 0; i < 16; i++) op_q.push_back(6'h08);
        run_instrs(16);

        // random mix with random memory latency
        rdy_rand = 1'b1;
        run_instrs(40);
        rdy_rand = 1'b0;

        // j: legal on one instance, trap on the other
        op_q.push_back(6'h02);
        run_instrs(1);
        rdy_rand = 1'b1;
        run_instrs(6);

        // unsupported opcode traps both; hold well past 20 cycles
        op_q.push_back(6'h3f);
        run_cycles(24);
        chk("trap_a", bus_a.state_o, S_TRAP);
        rdy_rand = 1'b0;
        cycle(1'b1);
        @(negedge clk);
        chk("ill_clr", bus_a.illegal_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0);
        step(1);
        if (ppos[0] == plen[0]) start_instr(1'b0);

        // reset while the lw waits in MEM_RD abandons it
        run_instrs(1);
        op_q.push_back(6'h23);
        run_instrs(1);
        op_q.push_back(6'h23);
        run_instrs(1);
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b1);
        run_cycles(3);
        chk("in_memrd", bus_a.state_o, S_MEM_RD);
        cycle(1'b1);
        chk("rst_st", bus_a.state_o, S_FETCH);
        chk("rst_ret", bus_a.retired_o, 0);
        run_instrs(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
